// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: turns make/break byte sequences into the active-low
// KEY_n level vector. Each new press is held low for at least HOLD_MIN cycles.
module ps2_key_decoder #(
  parameter int         HOLD_MIN     = 16,
  parameter int         STALE_CYCLES = 1048576,
  parameter logic [7:0] CODE_K3      = 8'h5A,
  parameter logic [7:0] CODE_K2      = 8'h76,
  parameter logic [7:0] CODE_K1      = 8'h29,
  parameter logic [7:0] CODE_K0      = 8'h2D
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [3:0] KEY_n,
  output logic       key_event,
  output logic [1:0] key_index
);

  localparam int HW = $clog2(HOLD_MIN + 1);
  localparam int SW = (STALE_CYCLES > 1) ? $clog2(STALE_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_MIN - 1);
  localparam logic [SW-1:0] STALE_LAST = SW'(STALE_CYCLES - 1);
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t          state;
  logic [SW-1:0]   stale_cnt;
  logic [HW-1:0]   hold_cnt [4];
  logic [3:0]      pend_rel;

  logic            code_hit;
  logic [1:0]      code_idx;
  logic            do_press;
  logic            do_release;

  always_comb begin
    code_hit = 1'b1;
    code_idx = 2'd0;
    if (scan_code == CODE_K3)      code_idx = 2'd3;
    else if (scan_code == CODE_K2) code_idx = 2'd2;
    else if (scan_code == CODE_K1) code_idx = 2'd1;
    else if (scan_code == CODE_K0) code_idx = 2'd0;
    else                           code_hit = 1'b0;
  end

  assign do_press   = scan_valid && (state == IDLE) && code_hit;
  assign do_release = scan_valid && (state == BRK)  && code_hit;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      stale_cnt <= '0;
      pend_rel  <= '0;
      KEY_n     <= 4'b1111;
      key_event <= 1'b0;
      key_index <= 2'd0;
      for (int i = 0; i < 4; i++) hold_cnt[i] <= '0;
    end else begin
      key_event <= 1'b0;

      // A byte always beats the stale timeout and is decoded in the current state.
      if (scan_valid) begin
        stale_cnt <= '0;
        case (state)
          IDLE: begin
            if (scan_code == BREAK_CODE)    state <= BRK;
            else if (scan_code == EXT_CODE) state <= EXT;
          end
          EXT:     state <= (scan_code == BREAK_CODE) ? EXT_BRK : IDLE;
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (stale_cnt == STALE_LAST) begin
          state     <= IDLE;
          stale_cnt <= '0;
        end else begin
          stale_cnt <= stale_cnt + 1'b1;
        end
      end

      for (int i = 0; i < 4; i++) begin
        if (hold_cnt[i] != '0) hold_cnt[i] <= hold_cnt[i] - 1'b1;

        if (pend_rel[i] && (hold_cnt[i] == '0)) begin
          KEY_n[i]    <= 1'b1;
          pend_rel[i] <= 1'b0;
        end

        // A repeat make while still held cancels any deferred release.
        if (do_press && (code_idx == 2'(i))) begin
          if (KEY_n[i]) begin
            KEY_n[i]    <= 1'b0;
            hold_cnt[i] <= HOLD_LOAD;
            key_event   <= 1'b1;
            key_index   <= 2'(i);
          end
          pend_rel[i] <= 1'b0;
        end

        if (do_release && (code_idx == 2'(i)) && !KEY_n[i]) begin
          if (hold_cnt[i] == '0) KEY_n[i]    <= 1'b1;
          else                   pend_rel[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus a random byte
// stream, all compared against a prefix-queue / timestamp model of key behaviour.
module tb_ps2_key_decoder;
  localparam int HOLD_MIN = 16;
  localparam int STALE    = 64;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [3:0] KEY_n;
  logic       key_event;
  logic [1:0] key_index;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: per key a held flag, press time and requested release time.
  bit          m_low   [4];
  bit          m_pend  [4];
  int          m_press_t [4];
  int          m_rel_t [4];
  bit          m_event;
  logic [1:0]  m_idx;
  byte unsigned pfx [$];
  int          m_last_t;

  ps2_key_decoder #(.HOLD_MIN(HOLD_MIN), .STALE_CYCLES(STALE)) dut (
    .Clk(Clk), .Reset(Reset), .scan_code(scan_code), .scan_valid(scan_valid),
    .KEY_n(KEY_n), .key_event(key_event), .key_index(key_index)
  );

  always #5 Clk = ~Clk;

  function automatic logic [3:0] m_key_n();
    logic [3:0] k;
    for (int i = 0; i < 4; i++) k[i] = ~m_low[i];
    return k;
  endfunction

  function automatic bit map_code(input byte unsigned b, output logic [1:0] idx);
    idx = 2'd0;
    case (b)
      8'h5A:   idx = 2'd3;
      8'h76:   idx = 2'd2;
      8'h29:   idx = 2'd1;
      8'h2D:   idx = 2'd0;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_low[i] = 0; m_pend[i] = 0; m_press_t[i] = 0; m_rel_t[i] = 0;
    end
    m_event = 0;
    m_idx = 2'd0;
    pfx.delete();
    m_last_t = 0;
  endtask

  task automatic model_edge(input bit v, input byte unsigned b);
    int t;
    logic [1:0] idx;
    bit hit, do_press, do_rel;
    t = cyc; idx = 2'd0; do_press = 0; do_rel = 0;
    m_event = 0;
    if (v) begin
      if (pfx.size() != 0 && (t - m_last_t - 1) >= STALE) pfx.delete();
      m_last_t = t;
      hit = map_code(b, idx);
      if (pfx.size() == 0) begin
        if (b == 8'hF0 || b == 8'hE0) pfx.push_back(b);
        else if (hit) do_press = 1;
      end else if (pfx.size() == 1 && pfx[0] == 8'hF0) begin
        do_rel = hit;
        pfx.delete();
      end else if (pfx.size() == 1 && b == 8'hF0) begin
        pfx.push_back(b);
      end else begin
        pfx.delete();
      end
    end
    if (do_press) begin
      if (m_low[idx]) m_pend[idx] = 0;
      else begin
        m_low[idx] = 1; m_pend[idx] = 0; m_press_t[idx] = t;
        m_event = 1; m_idx = idx;
      end
    end
    if (do_rel && m_low[idx]) begin
      m_pend[idx]  = 1;
      m_rel_t[idx] = (t > m_press_t[idx] + HOLD_MIN) ? t : m_press_t[idx] + HOLD_MIN;
    end
    for (int i = 0; i < 4; i++)
      if (m_pend[i] && t >= m_rel_t[i]) begin
        m_low[i] = 0; m_pend[i] = 0;
      end
  endtask

  task automatic step(input bit v, input byte unsigned b);
    @(negedge Clk);
    scan_valid = v;
    scan_code  = v ? b : 8'h00;
    @(posedge Clk);
    cyc++;
    model_edge(v, b);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; scan_valid = 1'b0; scan_code = 8'h00;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    n_checks++;
    if ({KEY_n, key_event, key_index} !== 7'b1111_0_00) begin
      n_fail++;
      $display("[TB] FAIL reset_state got KEY_n=%b ev=%b idx=%0d exp KEY_n=1111 ev=0 idx=0", KEY_n, key_event, key_index);
    end
    @(negedge Clk) Reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(0, 8'h00);
      n_checks++;
      if (KEY_n !== 4'b1111 || key_event !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_idle cyc=%0d got KEY_n=%b ev=%b exp KEY_n=1111 ev=0", cyc, KEY_n, key_event);
      end
    end
  endtask

  task automatic test_press_release();
    step(1, 8'h5A);
    n_checks++;
    if (KEY_n !== 4'b0111 || key_event !== 1'b1 || key_index !== 2'd3) begin
      n_fail++;
      $display("[TB] FAIL enter_press got KEY_n=%b ev=%b idx=%0d exp KEY_n=0111 ev=1 idx=3", KEY_n, key_event, key_index);
    end
    for (int i = 0; i < 40; i++) begin
      step(0, 8'h00);
      n_checks++;
      if ({KEY_n, key_event, key_index} !== {m_key_n(), m_event, m_idx}) begin
        n_fail++;
        $display("[TB] FAIL enter_hold cyc=%0d got KEY_n=%b ev=%b idx=%0d exp KEY_n=%b ev=%b idx=%0d", cyc, KEY_n, key_event, key_index, m_key_n(), m_event, m_idx);
      end
    end
    step(1, 8'hF0);
    step(1, 8'h5A);
    n_checks++;
    if (KEY_n !== 4'b1111 || key_event !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL enter_release got KEY_n=%b ev=%b exp KEY_n=1111 ev=0", KEY_n, key_event);
    end
  endtask

  task automatic test_deferred_release();
    int low_cnt;
    byte unsigned seq [3] = '{8'h76, 8'hF0, 8'h76};
    low_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < 3) step(1, seq[i]);
      else       step(0, 8'h00);
      if (KEY_n[2] === 1'b0) low_cnt++;
      n_checks++;
      if ({KEY_n, key_event, key_index} !== {m_key_n(), m_event, m_idx}) begin
        n_fail++;
        $display("[TB] FAIL deferred cyc=%0d got KEY_n=%b ev=%b idx=%0d exp KEY_n=%b ev=%b idx=%0d", cyc, KEY_n, key_event, key_index, m_key_n(), m_event, m_idx);
      end
    end
    n_checks++;
    if (low_cnt != HOLD_MIN) begin
      n_fail++;
      $display("[TB] FAIL deferred_width got %0d low cycles exp %0d", low_cnt, HOLD_MIN);
    end
  endtask

  task automatic test_extended();
    byte unsigned seq [5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    for (int i = 0; i < 5; i++) begin
      step(1, seq[i]);
      n_checks++;
      if (KEY_n !== 4'b1111 || key_event !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL extended_seq byte=%0d got KEY_n=%b ev=%b exp KEY_n=1111 ev=0", i, KEY_n, key_event);
      end
    end
    step(1, 8'h29);
    n_checks++;
    if (KEY_n !== 4'b1101 || key_event !== 1'b1 || key_index !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL extended_then_space got KEY_n=%b ev=%b idx=%0d exp KEY_n=1101 ev=1 idx=1", KEY_n, key_event, key_index);
    end
    step(1, 8'hF0);
    step(1, 8'h29);
    for (int i = 0; i < 20; i++) begin
      step(0, 8'h00);
      n_checks++;
      if ({KEY_n, key_event, key_index} !== {m_key_n(), m_event, m_idx}) begin
        n_fail++;
        $display("[TB] FAIL extended_tail cyc=%0d got KEY_n=%b ev=%b idx=%0d exp KEY_n=%b ev=%b idx=%0d", cyc, KEY_n, key_event, key_index, m_key_n(), m_event, m_idx);
      end
    end
  endtask

  task automatic test_typematic();
    int ev_cnt;
    ev_cnt = 0;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 100; i++) begin
        if (i == 0) step(1, 8'h5A);
        else        step(0, 8'h00);
        if (key_event === 1'b1) ev_cnt++;
        n_checks++;
        if (KEY_n[3] !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL typematic_held cyc=%0d got KEY_n=%b exp bit3=0", cyc, KEY_n);
        end
      end
    end
    n_checks++;
    if (ev_cnt != 1) begin
      n_fail++;
      $display("[TB] FAIL typematic_events got %0d exp 1", ev_cnt);
    end
    step(1, 8'hF0);
    step(1, 8'h5A);
    n_checks++;
    if (KEY_n !== 4'b1111) begin
      n_fail++;
      $display("[TB] FAIL typematic_release got KEY_n=%b exp 1111", KEY_n);
    end
  endtask

  task automatic test_stale();
    step(1, 8'hF0);
    repeat (STALE) step(0, 8'h00);
    step(1, 8'h2D);
    n_checks++;
    if (KEY_n !== 4'b1110 || key_event !== 1'b1 || key_index !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL stale_make got KEY_n=%b ev=%b idx=%0d exp KEY_n=1110 ev=1 idx=0", KEY_n, key_event, key_index);
    end
    repeat (20) step(0, 8'h00);
    // One idle cycle short of the timeout: the break prefix must still apply.
    step(1, 8'hF0);
    repeat (STALE - 1) step(0, 8'h00);
    step(1, 8'h2D);
    n_checks++;
    if (KEY_n !== 4'b1111 || key_event !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stale_boundary got KEY_n=%b ev=%b exp KEY_n=1111 ev=0", KEY_n, key_event);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 8'h5A);
    repeat (20) step(0, 8'h00);
    step(1, 8'hF0);
    @(negedge Clk);
    Reset = 1'b0;
    scan_valid = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (KEY_n !== 4'b1111 || key_event !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid got KEY_n=%b ev=%b exp KEY_n=1111 ev=0", KEY_n, key_event);
    end
    @(negedge Clk) Reset = 1'b1;
    step(1, 8'h5A);
    n_checks++;
    if (KEY_n !== 4'b0111 || key_event !== 1'b1 || key_index !== 2'd3) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_make got KEY_n=%b ev=%b idx=%0d exp KEY_n=0111 ev=1 idx=3", KEY_n, key_event, key_index);
    end
    step(1, 8'hF0);
    step(1, 8'h5A);
    for (int i = 0; i < 20; i++) begin
      step(0, 8'h00);
      n_checks++;
      if ({KEY_n, key_event, key_index} !== {m_key_n(), m_event, m_idx}) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_tail cyc=%0d got KEY_n=%b ev=%b idx=%0d exp KEY_n=%b ev=%b idx=%0d", cyc, KEY_n, key_event, key_index, m_key_n(), m_event, m_idx);
      end
    end
  endtask

  task automatic test_random();
    byte unsigned pool [10] = '{8'h5A, 8'h76, 8'h29, 8'h2D, 8'hF0, 8'hF0, 8'hE0, 8'h75, 8'h11, 8'hF0};
    int gap;
    for (int n = 0; n < 300; n++) begin
      gap = ($urandom_range(0, 19) == 0) ? $urandom_range(STALE - 2, STALE + 2) : $urandom_range(0, 6);
      for (int g = 0; g <= gap; g++) begin
        if (g == gap) step(1, pool[$urandom_range(0, 9)]);
        else          step(0, 8'h00);
        n_checks++;
        if ({KEY_n, key_event, key_index} !== {m_key_n(), m_event, m_idx}) begin
          n_fail++;
          $display("[TB] FAIL random cyc=%0d got KEY_n=%b ev=%b idx=%0d exp KEY_n=%b ev=%b idx=%0d", cyc, KEY_n, key_event, key_index, m_key_n(), m_event, m_idx);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_deferred_release();
    test_extended();
    test_typematic();
    test_stale();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
